// File: rtl/rule_merge_ctrl.sv
`default_nettype none
// rule_merge_ctrl -- merges a sorted temp batch with the active rule bank into the shadow bank, then swaps.
// Optional macro RULE_MERGE_DEDUP_EN drops batch keys equal to an existing rule. Rev 1.0
module rule_merge_ctrl #(
  parameter int DATA_W   = 64,
  parameter int RULE_AW  = 10,
  parameter int BATCH_AW = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [BATCH_AW:0]   temp_count0,
  input  logic [BATCH_AW:0]   temp_count1,
  output logic                temp_active,
  output logic [BATCH_AW-1:0] temp_rd_idx,
  output logic                sort_clear,
  output logic                sort_load,
  input  logic                sort_ready,
  output logic [BATCH_AW-1:0] sort_rd_idx,
  input  logic [DATA_W-1:0]   sort_rd_data,
  output logic [RULE_AW-1:0]  rule_rd_addr,
  input  logic [DATA_W-1:0]   rule_rd_data,
  output logic                wr_en,
  output logic [RULE_AW-1:0]  wr_addr,
  output logic [DATA_W-1:0]   wr_data,
  output logic                big_active,
  output logic [RULE_AW:0]    rule_count,
  input  logic                search_active,
  output logic                swap,
  output logic                overflow,
  output logic                busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_PRIME = 3'd2;
  localparam logic [2:0] S_MERGE = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;

  localparam logic [RULE_AW:0]    RULE_DEPTH = {1'b1, {RULE_AW{1'b0}}};
  localparam logic [RULE_AW:0]    RULE_ONE   = {{RULE_AW{1'b0}}, 1'b1};
  localparam logic [RULE_AW-1:0]  ADDR_ONE   = {{(RULE_AW-1){1'b0}}, 1'b1};
  localparam logic [BATCH_AW:0]   BATCH_ONE  = {{BATCH_AW{1'b0}}, 1'b1};
  localparam logic [BATCH_AW-1:0] IDX_ONE    = {{(BATCH_AW-1){1'b0}}, 1'b1};

  logic [2:0]          state;
  logic [BATCH_AW:0]   batch_len;
  logic [BATCH_AW-1:0] load_idx;
  logic [BATCH_AW:0]   t;
  logic [RULE_AW:0]    r;
  logic [RULE_AW:0]    w;

  logic [BATCH_AW:0] idle_count;
  logic              batch_valid;
  logic              rule_valid;
  logic              full;
  logic              take_batch;
  logic              take_rule;
  logic              skip_batch;

  assign idle_count  = temp_active ? temp_count1 : temp_count0;
  assign batch_valid = (t < batch_len);
  assign rule_valid  = (r < rule_count);
  assign full        = (w == RULE_DEPTH);

  // Strict less-than lets an equal rule key win, so existing entries stay ahead of new ones.
  always_comb begin
    take_batch = 1'b0;
    take_rule  = 1'b0;
    skip_batch = 1'b0;
    if (batch_valid && (!rule_valid || (sort_rd_data < rule_rd_data))) begin
      take_batch = 1'b1;
    end else if (rule_valid) begin
      take_rule = 1'b1;
`ifdef RULE_MERGE_DEDUP_EN
      skip_batch = batch_valid && (sort_rd_data == rule_rd_data);
`endif
    end
  end

  assign wr_en       = (state == S_MERGE) && !full && (take_batch || take_rule);
  assign wr_addr     = w[RULE_AW-1:0];
  assign wr_data     = take_batch ? sort_rd_data : rule_rd_data;
  assign sort_clear  = (state == S_IDLE);
  assign sort_load   = (state == S_LOAD);
  assign temp_rd_idx = load_idx;
  assign sort_rd_idx = t[BATCH_AW-1:0];
  assign busy        = (state != S_IDLE);

  // Prefetch the next rule the cycle one is consumed, hiding the registered RAM read.
  assign rule_rd_addr = (state != S_MERGE) ? '0 :
                        (wr_en && take_rule) ? (r[RULE_AW-1:0] + ADDR_ONE) : r[RULE_AW-1:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      temp_active <= 1'b0;
      big_active  <= 1'b0;
      rule_count  <= '0;
      overflow    <= 1'b0;
      swap        <= 1'b0;
      batch_len   <= '0;
      load_idx    <= '0;
      t           <= '0;
      r           <= '0;
      w           <= '0;
    end else begin
      swap <= 1'b0;
      case (state)
        S_IDLE: begin
          if (idle_count != '0) begin
            temp_active <= ~temp_active;
            batch_len   <= idle_count;
            load_idx    <= '0;
            state       <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (sort_ready) begin
            if ({1'b0, load_idx} == (batch_len - BATCH_ONE)) begin
              state <= S_PRIME;
            end else begin
              load_idx <= load_idx + IDX_ONE;
            end
          end
        end
        S_PRIME: begin
          t     <= '0;
          r     <= '0;
          w     <= '0;
          state <= S_MERGE;
        end
        S_MERGE: begin
          if (!batch_valid && !rule_valid) begin
            state <= S_WAIT;
          end else if (full) begin
            overflow <= 1'b1;
            state    <= S_WAIT;
          end else begin
            w <= w + RULE_ONE;
            if (take_batch || skip_batch) t <= t + BATCH_ONE;
            if (take_rule) r <= r + RULE_ONE;
          end
        end
        S_WAIT: begin
          if (!search_active) begin
            swap       <= 1'b1;
            big_active <= ~big_active;
            rule_count <= w;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/rule_merge_ctrl.md
Name: rule_merge_ctrl

Overview:
- Parametrised merge controller for the memory match block.
- Drains the filled temp-rule bank into the sorter, then merges the sorted batch with the active sorted rule bank. Writes the merged ascending stream into the shadow rule bank.
- Swaps banks once the search engine is idle.
- Generalises the fixed 16-entry / 512-rule flow: sized by parameter, uses a registered-read rule RAM, reports overflow, and exposes a merged-count output.

Parameters:
- DATA_W, 64, width of one concatenated rule key.
- RULE_AW, 10, rule bank address width; depth RULE_DEPTH = 2**RULE_AW.
- BATCH_AW, 4, temp/sorter address width; depth BATCH_DEPTH = 2**BATCH_AW.

Ports:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- temp_count0  in  BATCH_AW+1  entries held in temp bank 0
- temp_count1  in  BATCH_AW+1  entries held in temp bank 1
- temp_active  out  1  temp bank currently accepting inserts; the other bank is drained
- temp_rd_idx  out  BATCH_AW  read index into the drained temp bank (combinational read)
- sort_clear  out  1  clear sorter
- sort_load  out  1  temp_rd_idx entry offered to sorter
- sort_ready  in  1  sorter accepts offered entry this cycle
- sort_rd_idx  out  BATCH_AW  sorted-output index
- sort_rd_data  in  DATA_W  sorted entry at sort_rd_idx, same cycle
- rule_rd_addr  out  RULE_AW  active-bank read address; data returns next cycle
- rule_rd_data  in  DATA_W  registered RAM output
- wr_en  out  1  write merged entry to shadow bank
- wr_addr  out  RULE_AW  write address
- wr_data  out  DATA_W  merged entry
- big_active  out  1  rule bank used by search
- rule_count  out  RULE_AW+1  valid entries in active bank
- search_active  in  1  search in progress; swap blocked
- swap  out  1  one-cycle pulse: banks swapped
- overflow  out  1  sticky: a merge exceeded RULE_DEPTH
- busy  out  1  state != IDLE

Behaviour:
- Reset values: state IDLE, temp_active 0, big_active 0, rule_count 0, overflow 0, swap 0, wr_en 0, all indices 0.
- States:
  - IDLE: sort_clear=1. If the count of temp_active bank > 0: toggle temp_active, latch that count as B, go LOAD.
  - LOAD: sort_load=1. temp_rd_idx advances on sort_ready. On the cycle the entry at index B-1 is accepted, go PRIME.
  - PRIME: rule_rd_addr=0; sort_rd_idx=0; merged write pointer w=0; rule consumed pointer r=0; batch pointer t=0. Go MERGE next cycle. No writes.
  - MERGE: at most one wr_en per cycle.
    - Batch head = sort_rd_data at t, valid while t<B.
    - Rule head = rule_rd_data, valid while r<rule_count.
    - Take batch when batch valid and (rule invalid or batch < rule), unsigned compare. Otherwise take rule.
    - Taken item → wr_data, wr_addr=w, w++. Advance t or r accordingly.
    - rule_rd_addr = r+1 when rule taken this cycle, else r. This keeps the 1-cycle RAM latency transparent with zero bubbles.
    - When both heads are invalid, go WAIT_SWAP.
  - WAIT_SWAP: when !search_active, pulse swap, toggle big_active, rule_count<=w, go IDLE.
- Latency: merge of R rules and B batch entries = B load cycles (sort_ready high) + 1 PRIME + (R+B) MERGE + 1 + swap wait.
- Equal keys: rule entry emitted first (stable; batch sorts after existing).
- Overflow: if w reaches RULE_DEPTH while any head is still valid, suppress further wr_en, set overflow, discard the remainder, finish normally with rule_count=RULE_DEPTH.
- B=0 cannot occur: IDLE does not leave on a zero count.
- Inserts arriving during a merge go to the new temp_active bank and are picked up on the next IDLE visit.
- search_active held high: stay in WAIT_SWAP indefinitely, no writes.
- Reset mid-operation returns to IDLE. The shadow bank contents are undefined but unused; rule_count is cleared to 0.

Optional Feature:
- RULE_MERGE_DEDUP_EN
  - Defined: when batch head == rule head, emit the rule entry once and advance both t and r. rule_count reflects the deduplicated total.
  - Undefined: both entries are written, rule first.

Test Plan:
- Empty bank, temp_count0=3 {30,10,20}, sort_ready=1 → writes 10,20,30 at addr 0..2; swap pulse; big_active=1; rule_count=3.
- Active bank {5,15,25}, batch {10,20} → writes 5,10,15,20,25 on consecutive cycles, no bubbles; rule_count=5.
- search_active=1 held 20 cycles after merge done → swap=0 throughout; swap pulses 1 cycle after search_active falls.
- RULE_AW=2, rule_count=3, batch {1,2} → writes 1,2 and two rules; overflow=1; rule_count=4.
- Equal keys: rule {7}, batch {7} → without macro: two writes of 7, rule_count=2; with RULE_MERGE_DEDUP_EN: one write, rule_count=1.
- Reset asserted in MERGE → next cycle busy=0, rule_count=0, wr_en=0, big_active=0.
